// File: rtl/dsp_slice_pkg.sv
// rtl/dsp_slice_pkg.sv - shared width, mode encodings and datapath select indices for dsp_slice
package dsp_slice_pkg;

  localparam int DWIDTH = 8;

  typedef enum logic [1:0] {
    FUNC_INDEP = 2'b00,
    FUNC_DIFF  = 2'b01,
    FUNC_SUM   = 2'b10,
    FUNC_CHAIN = 2'b11
  } func_e;

  localparam int MUX_PRE_A = 0;
  localparam int MUX_PRE_B = 1;
  localparam int MUX_AY    = 2;
  localparam int MUX_BY    = 3;
  localparam int MUX_MUL_A = 4;
  localparam int MUX_MUL_B = 5;
  localparam int MUX_CHAIN = 6;
  localparam int MUX_OUT_B = 7;

endpackage

// File: rtl/dsp_premul.sv
// rtl/dsp_premul.sv - signed pre-adder (y+z / y-z) followed by an optional multiply by x
module dsp_premul #(
  parameter int DWIDTH = dsp_slice_pkg::DWIDTH
) (
  input  logic [DWIDTH-1:0]   y,
  input  logic [DWIDTH-1:0]   z,
  input  logic [DWIDTH-1:0]   x,
  input  logic                sub,
  input  logic                use_pre,
  input  logic                use_mul,
  output logic [2*DWIDTH-1:0] p
);

  logic [DWIDTH:0]   y_ext;
  logic [DWIDTH:0]   z_ext;
  logic [DWIDTH:0]   pre;
  logic [2*DWIDTH:0] pre_wide;
  logic [2*DWIDTH:0] x_wide;
  logic [2*DWIDTH:0] full;

  assign y_ext = {y[DWIDTH-1], y};
  assign z_ext = {z[DWIDTH-1], z};
  assign pre   = use_pre ? (sub ? y_ext - z_ext : y_ext + z_ext) : y_ext;

  // Sign-extend both factors to the full width so the low bits of the
  // unsigned product are the correct two's-complement product.
  assign pre_wide = {{DWIDTH{pre[DWIDTH]}}, pre};
  assign x_wide   = {{(DWIDTH+1){x[DWIDTH-1]}}, x};
  assign full     = pre_wide * x_wide;

  assign p = use_mul ? full[2*DWIDTH-1:0] : {{(DWIDTH-1){pre[DWIDTH]}}, pre};

endmodule

// File: rtl/dsp_slice.sv
// rtl/dsp_slice.sv - two-stage dual pre-add/multiply slice with mode combine, negate and accumulate
module dsp_slice #(
  parameter int DWIDTH = dsp_slice_pkg::DWIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                clr,
  input  logic                loadconst,
  input  logic                accumulate,
  input  logic                negate,
  input  logic                sub,
  input  logic [DWIDTH-1:0]   ay,
  input  logic [DWIDTH-1:0]   az,
  input  logic [DWIDTH-1:0]   ax,
  input  logic [DWIDTH-1:0]   by,
  input  logic [DWIDTH-1:0]   bz,
  input  logic [DWIDTH-1:0]   bx,
  input  logic [DWIDTH-1:0]   scanin,
  output logic [DWIDTH-1:0]   scanout,
  input  logic [2*DWIDTH-1:0] chainin,
  output logic [2*DWIDTH-1:0] chainout,
  output logic [2*DWIDTH-1:0] resulta,
  output logic [2*DWIDTH-1:0] resultb,
  input  logic [1:0]          func,
  input  logic [7:0]          muxsel,
  input  logic [4*DWIDTH-1:0] constant
);

  import dsp_slice_pkg::*;

  logic [DWIDTH-1:0]   ay_r, az_r, ax_r, by_r, bz_r, bx_r;
  logic [2*DWIDTH-1:0] chain_r;
  logic [4*DWIDTH-1:0] const_r;
  logic                sub_r, neg_r, acc_r, ldc_r;
  logic [1:0]          func_r;
  logic [7:0]          mux_r;
  logic                outb_r;

  logic [DWIDTH-1:0]   b_y_src;
  logic [2*DWIDTH-1:0] p_a, p_b, term_c;
  logic [2*DWIDTH-1:0] sum_a, sum_b, fin_a, fin_b, fb_a, fb_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      ay_r <= '0; az_r <= '0; ax_r <= '0;
      by_r <= '0; bz_r <= '0; bx_r <= '0;
      chain_r <= '0; const_r <= '0;
      sub_r <= 1'b0; neg_r <= 1'b0; acc_r <= 1'b0; ldc_r <= 1'b0;
      func_r <= '0; mux_r <= '0;
    end else if (enable) begin
      ay_r    <= muxsel[MUX_AY] ? ay : scanin;
      az_r    <= az;
      ax_r    <= ax;
      by_r    <= by;
      bz_r    <= bz;
      bx_r    <= bx;
      chain_r <= chainin;
      const_r <= constant;
      sub_r   <= sub;
      neg_r   <= negate;
      acc_r   <= accumulate;
      ldc_r   <= loadconst;
      func_r  <= func;
      mux_r   <= muxsel;
    end
  end

  // B can take the registered A y-operand, forming a short operand cascade.
  assign b_y_src = mux_r[MUX_BY] ? by_r : ay_r;

  dsp_premul #(.DWIDTH(DWIDTH)) u_premul_a (
    .y(ay_r), .z(az_r), .x(ax_r), .sub(sub_r),
    .use_pre(mux_r[MUX_PRE_A]), .use_mul(mux_r[MUX_MUL_A]), .p(p_a)
  );

  dsp_premul #(.DWIDTH(DWIDTH)) u_premul_b (
    .y(b_y_src), .z(bz_r), .x(bx_r), .sub(sub_r),
    .use_pre(mux_r[MUX_PRE_B]), .use_mul(mux_r[MUX_MUL_B]), .p(p_b)
  );

  assign term_c = mux_r[MUX_CHAIN] ? chain_r : '0;

  always_comb begin
    sum_a = p_a;
    sum_b = p_b;
    case (func_e'(func_r))
      FUNC_DIFF:  sum_b = p_a - p_b;
      FUNC_SUM: begin
        sum_a = p_a + p_b;
        sum_b = p_a + p_b;
      end
      FUNC_CHAIN: sum_b = p_a + p_b + term_c;
      default:    ;
    endcase
  end

  assign fin_a = neg_r ? -sum_a : sum_a;
  assign fin_b = neg_r ? -sum_b : sum_b;
  assign fb_a  = ldc_r ? const_r[2*DWIDTH-1:0]        : (acc_r ? resulta : '0);
  assign fb_b  = ldc_r ? const_r[4*DWIDTH-1:2*DWIDTH] : (acc_r ? resultb : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      resulta <= '0;
      resultb <= '0;
      outb_r  <= 1'b0;
    end else if (enable) begin
      resulta <= fin_a + fb_a;
      resultb <= fin_b + fb_b;
      outb_r  <= mux_r[MUX_OUT_B];
    end
  end

  assign chainout = outb_r ? resultb : resulta;
  assign scanout  = ay_r;

endmodule

// File: tb/tb_dsp_slice.sv
// tb/tb_dsp_slice.sv - scoreboard bench for dsp_slice: directed vectors plus randomized traffic vs a model
module tb_dsp_slice;

  logic        clk, rst_n, enable, clr, loadconst, accumulate, negate, sub;
  logic [7:0]  ay, az, ax, by, bz, bx, scanin, scanout, muxsel;
  logic [15:0] chainin, chainout, resulta, resultb;
  logic [1:0]  func;
  logic [31:0] constant;

  int checks = 0;
  int failures = 0;

  dsp_slice dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr),
    .loadconst(loadconst), .accumulate(accumulate), .negate(negate), .sub(sub),
    .ay(ay), .az(az), .ax(ax), .by(by), .bz(bz), .bx(bx),
    .scanin(scanin), .scanout(scanout), .chainin(chainin), .chainout(chainout),
    .resulta(resulta), .resultb(resultb), .func(func), .muxsel(muxsel),
    .constant(constant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  ay, az, ax, by, bz, bx;
    logic [15:0] chain;
    logic [31:0] cons;
    bit          sub, neg, acc, ldc;
    logic [1:0]  func;
    logic [7:0]  mux;
  } op_t;

  op_t         m_op;
  logic [15:0] m_a, m_b;
  bit          m_sel;
  logic [55:0] sb_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int premul(logic [7:0] y, logic [7:0] z, logic [7:0] x,
                                bit s, bit use_pre, bit use_mul);
    int yi, zi, xi, pre;
    yi = $signed(y);
    zi = $signed(z);
    xi = $signed(x);
    pre = use_pre ? (s ? yi - zi : yi + zi) : yi;
    return use_mul ? pre * xi : pre;
  endfunction

  task automatic model_clear();
    m_op = '{default: 0};
    m_a = '0;
    m_b = '0;
    m_sel = 1'b0;
  endtask

  // One rising edge of the reference: the captured operation finishes, new inputs are captured.
  task automatic model_edge();
    logic [15:0] pa, pb, c, sa, sb, fa, fb;
    if (!rst_n || clr) begin
      model_clear();
    end else if (enable) begin
      pa = 16'(premul(m_op.ay, m_op.az, m_op.ax, m_op.sub, m_op.mux[0], m_op.mux[4]));
      pb = 16'(premul(m_op.mux[3] ? m_op.by : m_op.ay, m_op.bz, m_op.bx,
                      m_op.sub, m_op.mux[1], m_op.mux[5]));
      c = m_op.mux[6] ? m_op.chain : 16'h0;
      case (m_op.func)
        2'd0: begin sa = pa;      sb = pb;          end
        2'd1: begin sa = pa;      sb = pa - pb;     end
        2'd2: begin sa = pa + pb; sb = pa + pb;     end
        default: begin sa = pa;   sb = pa + pb + c; end
      endcase
      if (m_op.neg) begin
        sa = -sa;
        sb = -sb;
      end
      fa = m_op.ldc ? m_op.cons[15:0]  : (m_op.acc ? m_a : 16'h0);
      fb = m_op.ldc ? m_op.cons[31:16] : (m_op.acc ? m_b : 16'h0);
      m_a = sa + fa;
      m_b = sb + fb;
      m_sel = m_op.mux[7];
      m_op.ay = muxsel[2] ? ay : scanin;
      m_op.az = az; m_op.ax = ax;
      m_op.by = by; m_op.bz = bz; m_op.bx = bx;
      m_op.chain = chainin; m_op.cons = constant;
      m_op.sub = sub; m_op.neg = negate; m_op.acc = accumulate; m_op.ldc = loadconst;
      m_op.func = func; m_op.mux = muxsel;
    end
  endtask

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      model_edge();
      sb_q.push_back({m_a, m_b, (m_sel ? m_b : m_a), m_op.ay});
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    logic [55:0] e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_resulta", resulta, e[55:40]);
      check("sb_resultb", resultb, e[39:24]);
      check("sb_chainout", chainout, e[23:8]);
      check("sb_scanout", scanout, e[7:0]);
    end
  end

  task automatic set_common();
    ay = 8'd1; az = 8'd2; ax = 8'd3; by = 8'd4; bz = 8'd5; bx = 8'd6;
    muxsel = 8'hFF; constant = 32'h12345678; chainin = 16'h0; scanin = 8'h0;
    func = 2'b00; negate = 1'b0; sub = 1'b0; loadconst = 1'b0; accumulate = 1'b0;
    enable = 1'b1; clr = 1'b0;
  endtask

  task automatic randomize_inputs();
    ay = 8'($urandom); az = 8'($urandom); ax = 8'($urandom);
    by = 8'($urandom); bz = 8'($urandom); bx = 8'($urandom);
    scanin = 8'($urandom); muxsel = 8'($urandom);
    chainin = 16'($urandom); constant = $urandom;
    func = 2'($urandom_range(0, 3));
    negate = 1'($urandom); sub = 1'($urandom);
    loadconst = ($urandom_range(0, 5) == 0);
    accumulate = 1'($urandom);
    enable = ($urandom_range(0, 9) < 8);
    clr = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    set_common();
    rst_n = 1'b1;
    model_clear();
    #1 rst_n = 1'b0;
    #1;
    check("reset_resulta", resulta, 16'h0);
    check("reset_resultb", resultb, 16'h0);
    check("reset_chainout", chainout, 16'h0);
    check("reset_scanout", scanout, 8'h0);
    step(1);
    rst_n = 1'b1;

    step(2);
    check("indep_resulta", resulta, 16'h0009);
    check("indep_resultb", resultb, 16'h0036);
    check("indep_chainout", chainout, 16'h0036);

    func = 2'b11; chainin = 16'h0100;
    step(2);
    check("chain_resultb", resultb, 16'h013F);
    check("chain_resulta", resulta, 16'h0009);

    func = 2'b10; chainin = 16'h0; negate = 1'b1;
    step(2);
    check("neg_resulta", resulta, 16'hFFC1);
    check("neg_resultb", resultb, 16'hFFC1);

    negate = 1'b0; loadconst = 1'b1;
    step(2);
    check("ldc_resulta", resulta, 16'h56B7);
    check("ldc_resultb", resultb, 16'h1273);

    func = 2'b00; loadconst = 1'b0; accumulate = 1'b1;
    step(4);
    check("acc_resulta", resulta, 16'h56D2);

    enable = 1'b0;
    ay = 8'h55; func = 2'b10; accumulate = 1'b0;
    step(3);
    check("hold_resulta", resulta, 16'h56D2);
    check("hold_scanout", scanout, 8'h01);

    set_common();
    accumulate = 1'b1;
    step(1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_resulta", resulta, 16'h0);
    check("async_rst_resultb", resultb, 16'h0);
    check("async_rst_chainout", chainout, 16'h0);
    check("async_rst_scanout", scanout, 8'h0);
    model_clear();
    step(1);
    rst_n = 1'b1;
    enable = 1'b0;
    step(2);
    check("release_resulta", resulta, 16'h0);

    set_common();
    step(2);
    clr = 1'b1; enable = 1'b0;
    step(1);
    check("clr_resulta", resulta, 16'h0);
    check("clr_resultb", resultb, 16'h0);
    check("clr_scanout", scanout, 8'h0);

    set_common();
    sub = 1'b1;
    step(2);
    check("sub_resulta", resulta, 16'hFFFD);
    check("sub_resultb", resultb, 16'hFFFA);

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step(1);
    end

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
